// File: rtl/munoc_apb_to_axi_master_bridge_pkg.sv
// munoc_apb_to_axi_master_bridge_pkg: AXI field widths, burst encoding and bridge FSM states
package munoc_apb_to_axi_master_bridge_pkg;
  localparam int BW_AXI_ALEN = 8;
  localparam int BW_AXI_ASIZE = 3;
  localparam int BW_AXI_ABURST = 2;
  localparam int BW_AXI_BRESP = 2;
  localparam int BW_AXI_RRESP = 2;
  localparam logic [BW_AXI_ABURST-1:0] AXI_BURST_INCR = 2'b01;
  typedef enum logic [2:0] {ST_IDLE, ST_WREQ, ST_WRESP, ST_RREQ, ST_RRESP, ST_DONE} state_t;
  function automatic logic [BW_AXI_ASIZE-1:0] axi_size(input int bw_data);
    return BW_AXI_ASIZE'($clog2(bw_data / 8));
  endfunction
endpackage

// File: rtl/munoc_apb_to_axi_master_bridge.sv
// munoc_apb_to_axi_master_bridge: APB3 completer issuing one single-beat AXI4 transaction per transfer
module munoc_apb_to_axi_master_bridge
  import munoc_apb_to_axi_master_bridge_pkg::*;
#(
  parameter int BW_ADDR = 32,
  parameter int BW_DATA = 32,
  parameter int BW_AXI_TID = 4,
  parameter int AXI_TID = 0
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     comm_disable,
  input  logic [BW_ADDR-1:0]       mpaddr,
  input  logic                     mpwrite,
  input  logic                     mpsel,
  input  logic                     mpenable,
  input  logic [BW_DATA-1:0]       mpwdata,
  output logic [BW_DATA-1:0]       mprdata,
  output logic                     mpready,
  output logic                     mpslverr,
  output logic [BW_AXI_TID-1:0]    mxawid,
  output logic [BW_ADDR-1:0]       mxawaddr,
  output logic [BW_AXI_ALEN-1:0]   mxawlen,
  output logic [BW_AXI_ASIZE-1:0]  mxawsize,
  output logic [BW_AXI_ABURST-1:0] mxawburst,
  output logic                     mxawvalid,
  input  logic                     mxawready,
  output logic [BW_DATA-1:0]       mxwdata,
  output logic [BW_DATA/8-1:0]     mxwstrb,
  output logic                     mxwlast,
  output logic                     mxwvalid,
  input  logic                     mxwready,
  input  logic [BW_AXI_TID-1:0]    mxbid,
  input  logic [BW_AXI_BRESP-1:0]  mxbresp,
  input  logic                     mxbvalid,
  output logic                     mxbready,
  output logic [BW_AXI_TID-1:0]    mxarid,
  output logic [BW_ADDR-1:0]       mxaraddr,
  output logic [BW_AXI_ALEN-1:0]   mxarlen,
  output logic [BW_AXI_ASIZE-1:0]  mxarsize,
  output logic [BW_AXI_ABURST-1:0] mxarburst,
  output logic                     mxarvalid,
  input  logic                     mxarready,
  input  logic [BW_AXI_TID-1:0]    mxrid,
  input  logic [BW_DATA-1:0]       mxrdata,
  input  logic [BW_AXI_RRESP-1:0]  mxrresp,
  input  logic                     mxrlast,
  input  logic                     mxrvalid,
  output logic                     mxrready
);
  state_t state, state_nx;
  logic [BW_ADDR-1:0] addr;
  logic [BW_DATA-1:0] wdata;
  logic err, aw_done, w_done, aw_hs, w_hs;
  logic unused;
  assign unused = ^{mxbid, mxrid, mxrlast, mxbresp[0], mxrresp[0]};
  assign aw_hs = mxawvalid & mxawready;
  assign w_hs = mxwvalid & mxwready;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (mpsel) state_nx = comm_disable ? ST_DONE : mpwrite ? ST_WREQ : ST_RREQ;
      ST_WREQ:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_nx = ST_WRESP;
      ST_WRESP: if (mxbvalid) state_nx = ST_DONE;
      ST_RREQ:  if (mxarready) state_nx = ST_RRESP;
      ST_RRESP: if (mxrvalid) state_nx = ST_DONE;
      ST_DONE:  if (mpready | ~mpsel) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) state <= ST_IDLE;
    else state <= state_nx;
  // AW and W complete independently; the done flags keep each valid low after its own handshake
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      addr <= '0;
      wdata <= '0;
      err <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      mprdata <= '0;
    end else begin
      if (state == ST_IDLE && mpsel) begin
        addr <= mpaddr;
        wdata <= mpwdata;
        err <= comm_disable;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        if (comm_disable) mprdata <= '0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (state == ST_WRESP && mxbvalid) err <= mxbresp[1];
      if (state == ST_RRESP && mxrvalid) begin
        mprdata <= mxrdata;
        err <= mxrresp[1];
      end
    end
  assign mpready = (state == ST_DONE) & mpsel & mpenable;
  assign mpslverr = mpready & err;
  assign mxawid = BW_AXI_TID'(AXI_TID);
  assign mxawaddr = addr;
  assign mxawlen = '0;
  assign mxawsize = axi_size(BW_DATA);
  assign mxawburst = AXI_BURST_INCR;
  assign mxawvalid = (state == ST_WREQ) & ~aw_done;
  assign mxwdata = wdata;
  assign mxwstrb = '1;
  assign mxwlast = 1'b1;
  assign mxwvalid = (state == ST_WREQ) & ~w_done;
  assign mxbready = state == ST_WRESP;
  assign mxarid = BW_AXI_TID'(AXI_TID);
  assign mxaraddr = addr;
  assign mxarlen = '0;
  assign mxarsize = axi_size(BW_DATA);
  assign mxarburst = AXI_BURST_INCR;
  assign mxarvalid = state == ST_RREQ;
  assign mxrready = state == ST_RRESP;
endmodule

// File: tb/tb_munoc_apb_to_axi_master_bridge.sv
// tb_munoc_apb_to_axi_master_bridge: randomized APB transfers against a latency/payload reference model
module tb_munoc_apb_to_axi_master_bridge;
  logic clk = 0, rstnn = 0;
  logic comm_disable, mpwrite, mpsel, mpenable, mpready, mpslverr;
  logic [31:0] mpaddr, mpwdata, mprdata;
  logic [3:0] mxawid, mxbid, mxarid, mxrid;
  logic [31:0] mxawaddr, mxwdata, mxaraddr, mxrdata;
  logic [7:0] mxawlen, mxarlen;
  logic [2:0] mxawsize, mxarsize;
  logic [1:0] mxawburst, mxarburst, mxbresp, mxrresp;
  logic [3:0] mxwstrb;
  logic mxawvalid, mxawready, mxwlast, mxwvalid, mxwready, mxbvalid, mxbready;
  logic mxarvalid, mxarready, mxrlast, mxrvalid, mxrready;
  int n_cmp = 0, n_bad = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int aw_dly, w_dly, b_dly, ar_dly, r_dly, const_bad = 0, stab_bad = 0;
  logic [1:0] b_resp_k, r_resp_k;
  logic [31:0] r_data_k, cap_awaddr, cap_wdata, cap_araddr, h_awaddr, h_wdata, h_araddr;
  logic [3:0] cap_wstrb;
  logic aw_hold, w_hold, ar_hold;
  always #5 clk = ~clk;
  munoc_apb_to_axi_master_bridge dut (
    .clk(clk), .rstnn(rstnn), .comm_disable(comm_disable), .mpaddr(mpaddr), .mpwrite(mpwrite),
    .mpsel(mpsel), .mpenable(mpenable), .mpwdata(mpwdata), .mprdata(mprdata), .mpready(mpready),
    .mpslverr(mpslverr), .mxawid(mxawid), .mxawaddr(mxawaddr), .mxawlen(mxawlen),
    .mxawsize(mxawsize), .mxawburst(mxawburst), .mxawvalid(mxawvalid), .mxawready(mxawready),
    .mxwdata(mxwdata), .mxwstrb(mxwstrb), .mxwlast(mxwlast), .mxwvalid(mxwvalid),
    .mxwready(mxwready), .mxbid(mxbid), .mxbresp(mxbresp), .mxbvalid(mxbvalid),
    .mxbready(mxbready), .mxarid(mxarid), .mxaraddr(mxaraddr), .mxarlen(mxarlen),
    .mxarsize(mxarsize), .mxarburst(mxarburst), .mxarvalid(mxarvalid), .mxarready(mxarready),
    .mxrid(mxrid), .mxrdata(mxrdata), .mxrresp(mxrresp), .mxrlast(mxrlast),
    .mxrvalid(mxrvalid), .mxrready(mxrready)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // AXI completer model: handshake bookkeeping, payload capture and stability watch
  always @(posedge clk)
    if (!rstnn) begin
      aw_hold = 0;
      w_hold = 0;
      ar_hold = 0;
    end else begin
      if (aw_hold && (!mxawvalid || mxawaddr !== h_awaddr)) stab_bad++;
      if (w_hold && (!mxwvalid || mxwdata !== h_wdata)) stab_bad++;
      if (ar_hold && (!mxarvalid || mxaraddr !== h_araddr)) stab_bad++;
      aw_hold = mxawvalid && !mxawready;
      w_hold = mxwvalid && !mxwready;
      ar_hold = mxarvalid && !mxarready;
      h_awaddr = mxawaddr;
      h_wdata = mxwdata;
      h_araddr = mxaraddr;
      if (mxawvalid && mxawready) begin
        aw_cnt++;
        cap_awaddr = mxawaddr;
        if (mxawlen != 0 || mxawsize != 2 || mxawburst != 1 || mxawid != 0) const_bad++;
      end
      if (mxwvalid && mxwready) begin
        w_cnt++;
        cap_wdata = mxwdata;
        cap_wstrb = mxwstrb;
        if (!mxwlast) const_bad++;
      end
      if (mxarvalid && mxarready) begin
        ar_cnt++;
        cap_araddr = mxaraddr;
        if (mxarlen != 0 || mxarsize != 2 || mxarburst != 1 || mxarid != 0) const_bad++;
      end
      if (mxbvalid && mxbready) b_cnt++;
      if (mxrvalid && mxrready) r_cnt++;
    end
  always @(negedge clk) begin
    mxawready = mxawvalid && aw_wait >= aw_dly;
    if (mxawvalid) aw_wait++;
    mxwready = mxwvalid && w_wait >= w_dly;
    if (mxwvalid) w_wait++;
    mxarready = mxarvalid && ar_wait >= ar_dly;
    if (mxarvalid) ar_wait++;
    if (aw_cnt > 0 && w_cnt > 0 && b_cnt == 0) begin
      mxbvalid = b_wait >= b_dly;
      b_wait++;
    end else mxbvalid = 0;
    if (ar_cnt > 0 && r_cnt == 0) begin
      mxrvalid = r_wait >= r_dly;
      r_wait++;
    end else mxrvalid = 0;
    mxbresp = b_resp_k;
    mxrresp = r_resp_k;
    mxrdata = mxrvalid ? r_data_k : $urandom;
    mxbid = 4'($urandom);
    mxrid = 4'($urandom);
    mxrlast = 1;
  end
  task automatic arm(input int ad, wd, bd, ard, rd, input logic [1:0] br, rr, input logic [31:0] rdat);
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_dly = ad; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    b_resp_k = br; r_resp_k = rr; r_data_k = rdat;
  endtask
  task automatic do_xfer(input logic wr, cd, input logic [31:0] addr, data, input int ad, wd, bd,
                         ard, rd, input logic [1:0] br, rr, input logic [31:0] rdat, input logic gap);
    int lat, exp_lat;
    logic done, got_err, exp_err;
    logic [31:0] got_rd;
    arm(ad, wd, bd, ard, rd, br, rr, rdat);
    @(negedge clk);
    mpsel = 1; mpenable = 0; mpwrite = wr; mpaddr = addr; mpwdata = data; comm_disable = cd;
    done = 0; lat = 0; got_err = 0; got_rd = 0;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(negedge clk);
      mpenable = 1;
      comm_disable = 1'($urandom);
      #1;
      if (mpready) begin
        done = 1; lat = n; got_rd = mprdata; got_err = mpslverr;
      end
    end
    if (!done) begin
      check("timeout", 0, 1);
      mpsel = 0; mpenable = 0;
      return;
    end
    @(posedge clk);
    #1;
    check("ready_one_cycle", mpready, 0);
    exp_lat = cd ? 1 : wr ? 3 + (ad > wd ? ad : wd) + bd : 3 + ard + rd;
    exp_err = cd ? 1 : wr ? br[1] : rr[1];
    check("latency", lat, exp_lat);
    check("slverr", got_err, exp_err);
    check("axi_counts", {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt), 8'(r_cnt)},
          cd ? 40'h0 : wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
    if (cd) check("rdata_disabled", got_rd, 0);
    else if (wr) begin
      check("awaddr", cap_awaddr, addr);
      check("wdata", cap_wdata, data);
      check("wstrb", cap_wstrb, 4'hF);
    end else begin
      check("araddr", cap_araddr, addr);
      check("rdata", got_rd, rdat);
    end
    if (gap) begin
      @(negedge clk);
      mpsel = 0; mpenable = 0;
    end
  endtask
  initial begin
    int ok;
    logic wr, cd;
    mpsel = 0; mpenable = 0; mpwrite = 0; mpaddr = 0; mpwdata = 0; comm_disable = 0;
    arm(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_ctrl", {mxawvalid, mxwvalid, mxarvalid, mxbready, mxrready, mpready, mpslverr}, 0);
    check("reset_rdata", mprdata, 0);
    rstnn = 1;
    do_xfer(1, 0, 32'h1000_0040, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    do_xfer(0, 0, 32'h2000_0000, 0, 0, 0, 0, 3, 0, 2'b00, 2'b00, 32'h1234_5678, 1);
    do_xfer(1, 0, 32'h3000_0010, 32'hCAFE_F00D, 2, 0, 1, 0, 0, 2'b10, 2'b00, 0, 1);
    do_xfer(0, 1, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFFF, 1);
    do_xfer(0, 0, 32'h5000_0008, 0, 0, 0, 0, 1, 2, 2'b00, 2'b10, 32'hA5A5_5A5A, 0);
    do_xfer(1, 0, 32'h5000_000C, 32'h0BAD_CAFE, 1, 3, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    arm(0, 0, 8, 0, 0, 2'b00, 2'b00, 0);
    @(negedge clk);
    mpsel = 1; mpenable = 0; mpwrite = 1; mpaddr = 32'h6000_0000; mpwdata = 32'h1111_2222; comm_disable = 0;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      mpenable = 1;
      #1;
      if (mxbready) ok = 1;
    end
    check("reach_wresp", ok, 1);
    rstnn = 0;
    #1;
    check("midreset_ctrl", {mxawvalid, mxwvalid, mxarvalid, mxbready, mxrready, mpready, mpslverr}, 0);
    check("midreset_rdata", mprdata, 0);
    mpsel = 0; mpenable = 0;
    @(negedge clk);
    rstnn = 1;
    do_xfer(0, 0, 32'h7000_0004, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h600D_D00D, 1);
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      cd = ($urandom_range(0, 5) == 0);
      do_xfer(wr, cd, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom),
              2'($urandom), $urandom, 1'($urandom));
    end
    check("axi_constants", const_bad, 0);
    check("valid_payload_stable", stab_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
